// File: rtl/instruction_encoder_loader_if.sv
// Operation-entry and instruction-memory write bus for instruction_encoder_loader.
// The master drives sessions and operation fields; the slave (the loader) drives memory writes.
interface instruction_encoder_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] count;
  logic              op_valid;
  logic              op_ready;
  logic [10:0]       ALUCtl_code;
  logic [3:0]        cond_field;
  logic              set_flags;
  logic [3:0]        rd;
  logic [3:0]        rn;
  logic [3:0]        rm;
  logic [7:0]        shift;
  logic [3:0]        rotate;
  logic [7:0]        immediateValue;
  logic [23:0]       br_address;
  logic [11:0]       dt_address;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              bad_op;

  modport master (
    output start, base_addr, count, op_valid, ALUCtl_code, cond_field, set_flags,
           rd, rn, rm, shift, rotate, immediateValue, br_address, dt_address,
    input  op_ready, imem_wr_en, imem_addr, imem_wdata, busy, done, bad_op
  );

  modport slave (
    input  start, base_addr, count, op_valid, ALUCtl_code, cond_field, set_flags,
           rd, rn, rm, shift, rotate, immediateValue, br_address, dt_address,
    output op_ready, imem_wr_en, imem_addr, imem_wdata, busy, done, bad_op
  );
endinterface

// File: rtl/instruction_encoder_loader.sv
// Encodes decoded operation fields into 32-bit instruction words and writes them to instruction memory.
// Optional INSTR_ENC_CHECKSUM_EN adds a per-session XOR checksum output.
module instruction_encoder_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  instruction_encoder_loader_if.slave   bus
`ifdef INSTR_ENC_CHECKSUM_EN
  ,
  output logic [31:0]                   checksum
`endif
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccept = 2'd1;
  localparam logic [1:0] StWrite  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [1:0] LoReg = 2'd0;
  localparam logic [1:0] LoImm = 2'd1;
  localparam logic [1:0] LoDt  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [31:0]       word_q, word_d;
  logic              bad_q, bad_d;

  logic              enc_ok;
  logic              is_branch;
  logic [1:0]        lo_sel;
  logic [7:0]        hi;
  logic [19:0]       lo;
  logic [31:0]       enc_word;

  // Field layout mirrors the CPU decoder; compare/test ops force S=1.
  always_comb begin
    enc_ok    = 1'b1;
    is_branch = 1'b0;
    lo_sel    = LoReg;
    hi        = 8'h00;
    case (bus.ALUCtl_code)
      11'd0:   hi = {7'b0000100, bus.set_flags};
      11'd1:   begin hi = {7'b0010100, bus.set_flags}; lo_sel = LoImm; end
      11'd2:   hi = {7'b0000010, bus.set_flags};
      11'd3:   hi = {7'b0000000, bus.set_flags};
      11'd4:   hi = {7'b0001100, bus.set_flags};
      11'd5:   hi = {7'b0000001, bus.set_flags};
      11'd6:   hi = {7'b0001101, bus.set_flags};
      11'd7:   hi = {7'b0001111, bus.set_flags};
      11'd8:   hi = 8'b00010101;
      11'd9:   hi = 8'b00010001;
      11'd10:  hi = 8'b00010011;
      11'd11:  hi = {7'b0001110, bus.set_flags};
      11'd12:  begin hi = {7'b0011101, bus.set_flags}; lo_sel = LoImm; end
      11'd13:  begin hi = 8'b00110101; lo_sel = LoImm; end
      11'd41:  begin hi = 8'b01011000; lo_sel = LoDt; end
      11'd42:  begin hi = 8'b01011001; lo_sel = LoDt; end
      11'd31:  is_branch = 1'b1;
      11'd32:  is_branch = 1'b1;
      default: enc_ok = 1'b0;
    endcase

    case (lo_sel)
      LoImm:   lo = {bus.rn, bus.rd, bus.rotate, bus.immediateValue};
      LoDt:    lo = {bus.rn, bus.rd, bus.dt_address};
      default: lo = {bus.rn, bus.rd, bus.shift, bus.rm};
    endcase

    if (is_branch) begin
      enc_word = {bus.cond_field, 3'b101, bus.ALUCtl_code == 11'd32, bus.br_address};
    end else begin
      enc_word = {bus.cond_field, hi, lo};
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    bad_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d      = bus.base_addr;
          remaining_d = bus.count;
          state_d     = (bus.count == '0) ? StDone : StAccept;
        end
      end
      StAccept: begin
        if (bus.op_valid) begin
          if (enc_ok) begin
            word_d  = enc_word;
            state_d = StWrite;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      StWrite: begin
        addr_d      = addr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        state_d     = (remaining_q == ADDR_W'(1)) ? StDone : StAccept;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      bad_q       <= bad_d;
    end
  end

  // Strobe decodes straight from state so an async reset kills it within the same cycle.
  assign bus.op_ready   = (state_q == StAccept);
  assign bus.imem_wr_en = (state_q == StWrite);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.bad_op     = bad_q;

`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0] chk_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_q <= '0;
    end else if (state_q == StIdle && bus.start) begin
      chk_q <= '0;
    end else if (state_q == StWrite) begin
      chk_q <= chk_q ^ word_q;
    end
  end

  assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Randomized self-checking bench for instruction_encoder_loader against a field-level encoding model.
module tb_instruction_encoder_loader;

  typedef struct {
    logic [10:0] code;
    logic [3:0]  cond;
    logic        s;
    logic [3:0]  rd, rn, rm;
    logic [7:0]  shift;
    logic [3:0]  rot;
    logic [7:0]  imm;
    logic [23:0] br;
    logic [11:0] dt;
  } op_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instruction_encoder_loader_if #(.ADDR_W(8)) bus ();
`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  instruction_encoder_loader #(.ADDR_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef INSTR_ENC_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int bad_cnt = 0;
  logic [7:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  logic [7:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  op_t         sess_ops[$];
  int          exp_bad;
  logic [31:0] exp_xor;

  always @(negedge clk) begin
    cyc++;
    if (bus.imem_wr_en === 1'b1) begin
      obs_addr.push_back(bus.imem_addr);
      obs_data.push_back(bus.imem_wdata);
      obs_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.bad_op === 1'b1) bad_cnt++;
  end

  // ARM-style data-processing view: {00, I, opcode, S}; memory and branch forms separately.
  function automatic bit ref_encode(input op_t o, output logic [31:0] w);
    logic [3:0] opc;
    bit         i_form, s_forced;
    w = '0;
    i_form = 0;
    s_forced = 0;
    opc = 4'h0;
    case (o.code)
      11'd31, 11'd32: begin
        w = {o.cond, 3'b101, (o.code == 11'd32), o.br};
        return 1'b1;
      end
      11'd41, 11'd42: begin
        w = {o.cond, 6'b010110, 1'b0, (o.code == 11'd42), o.rn, o.rd, o.dt};
        return 1'b1;
      end
      11'd0:  opc = 4'b0100;
      11'd1:  begin opc = 4'b0100; i_form = 1; end
      11'd2:  opc = 4'b0010;
      11'd3:  opc = 4'b0000;
      11'd4:  opc = 4'b1100;
      11'd5:  opc = 4'b0001;
      11'd6:  opc = 4'b1101;
      11'd7:  opc = 4'b1111;
      11'd8:  begin opc = 4'b1010; s_forced = 1; end
      11'd9:  begin opc = 4'b1000; s_forced = 1; end
      11'd10: begin opc = 4'b1001; s_forced = 1; end
      11'd11: opc = 4'b1110;
      11'd12: begin opc = 4'b1101; i_form = 1; end
      11'd13: begin opc = 4'b1010; i_form = 1; s_forced = 1; end
      default: return 1'b0;
    endcase
    w = {o.cond, 2'b00, i_form, opc, (o.s | s_forced), o.rn, o.rd,
         (i_form ? {o.rot, o.imm} : {o.shift, o.rm})};
    return 1'b1;
  endfunction

  function automatic op_t mk_op(input int code);
    op_t o;
    o.code = 11'(code);
    o.cond = 4'($urandom_range(0, 15));
    o.s = 1'($urandom_range(0, 1));
    o.rd = 4'($urandom_range(0, 15));
    o.rn = 4'($urandom_range(0, 15));
    o.rm = 4'($urandom_range(0, 15));
    o.shift = 8'($urandom_range(0, 255));
    o.rot = 4'($urandom_range(0, 15));
    o.imm = 8'($urandom_range(0, 255));
    o.br = 24'($urandom);
    o.dt = 12'($urandom_range(0, 4095));
    return o;
  endfunction

  function automatic op_t rand_legal();
    int legal[18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 31, 32, 41, 42};
    return mk_op(legal[$urandom_range(0, 17)]);
  endfunction

  function automatic op_t rand_illegal();
    int c;
    do c = $urandom_range(14, 200); while (c == 31 || c == 32 || c == 41 || c == 42);
    return mk_op(c);
  endfunction

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    exp_addr.delete(); exp_data.delete();
    exp_bad = 0;
    exp_xor = '0;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] c);
    bus.base_addr = b;
    bus.count = c;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Returns #1 after the accepting edge.
  task automatic drive_op(input string name, input op_t o, output bit ok);
    bit rdy = 0;
    bus.ALUCtl_code = o.code; bus.cond_field = o.cond; bus.set_flags = o.s;
    bus.rd = o.rd; bus.rn = o.rn; bus.rm = o.rm; bus.shift = o.shift;
    bus.rotate = o.rot; bus.immediateValue = o.imm; bus.br_address = o.br;
    bus.dt_address = o.dt;
    bus.op_valid = 1'b1;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge clk);
      if (bus.op_ready === 1'b1) rdy = 1;
    end
    if (!rdy) begin
      n_cmp++; n_err++;
      $display("FAIL %s op_ready: got 0 for 20 cycles, required 1", name);
      bus.op_valid = 1'b0;
      ok = 0;
      return;
    end
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    ok = 1;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s done: got no pulse in 40 cycles, required pulse", name);
    end
`ifdef INSTR_ENC_CHECKSUM_EN
    n_cmp++;
    if (checksum !== exp_xor) begin
      n_err++;
      $display("FAIL %s checksum: got %h, required %h", name, checksum, exp_xor);
    end
`endif
  endtask

  // Drives sess_ops through one session and checks writes, bad_op pulses and completion.
  task automatic run_session(input string name, input logic [7:0] base, input logic [7:0] cnt);
    int k = 0;
    int b0, d0;
    bit ok;
    logic [31:0] w;
    clear_obs();
    b0 = bad_cnt;
    d0 = done_cnt;
    do_start(base, cnt);
    foreach (sess_ops[i]) begin
      drive_op(name, sess_ops[i], ok);
      if (ref_encode(sess_ops[i], w)) begin
        exp_addr.push_back(base + 8'(k));
        exp_data.push_back(w);
        exp_xor ^= w;
        k++;
      end else begin
        exp_bad++;
      end
    end
    wait_done(name);
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s post_done: got done=%b busy=%b, required 0 0", name, bus.done, bus.busy);
    end
    n_cmp++;
    if (obs_data.size() != exp_data.size()) begin
      n_err++;
      $display("FAIL %s write_count: got %0d, required %0d", name, obs_data.size(),
               exp_data.size());
    end else begin
      foreach (exp_data[i]) begin
        n_cmp++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          n_err++;
          $display("FAIL %s write[%0d]: got %h@%h, required %h@%h", name, i, obs_data[i],
                   obs_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    end
    n_cmp++;
    if (bad_cnt - b0 != exp_bad || done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL %s pulses: got bad=%0d done=%0d, required bad=%0d done=1", name,
               bad_cnt - b0, done_cnt - d0, exp_bad);
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.op_valid = 0; bus.base_addr = 0; bus.count = 0;
    bus.ALUCtl_code = 0; bus.cond_field = 0; bus.set_flags = 0; bus.rd = 0; bus.rn = 0;
    bus.rm = 0; bus.shift = 0; bus.rotate = 0; bus.immediateValue = 0; bus.br_address = 0;
    bus.dt_address = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.op_ready, bus.imem_wr_en, bus.busy, bus.done, bus.bad_op} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy/wr/busy/done/bad=%b, required 00000",
               {bus.op_ready, bus.imem_wr_en, bus.busy, bus.done, bus.bad_op});
    end
    n_cmp++;
    if (bus.imem_addr !== 8'h00 || bus.imem_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_bus: got %h@%h, required 0@0", bus.imem_wdata, bus.imem_addr);
    end
`ifdef INSTR_ENC_CHECKSUM_EN
    n_cmp++;
    if (checksum !== 32'h0) begin
      n_err++;
      $display("FAIL reset_checksum: got %h, required 0", checksum);
    end
`endif
  endtask

  task automatic test_directed();
    op_t o;
    sess_ops.delete();
    o = mk_op(0); o.cond = 4'hE; o.rd = 5; o.rn = 7; o.rm = 6; o.shift = 0; o.s = 0;
    sess_ops.push_back(o);
    run_session("add", 8'h10, 8'd1);
    n_cmp++;
    if (obs_data.size() < 1 || obs_data[0] !== 32'hE0875006 || obs_addr[0] !== 8'h10) begin
      n_err++;
      $display("FAIL add_literal: got %h@%h, required e0875006@10",
               obs_data.size() ? obs_data[0] : 32'hx, obs_addr.size() ? obs_addr[0] : 8'hx);
    end

    sess_ops.delete();
    o = mk_op(6); o.cond = 4'hE; o.rd = 0; o.rm = 3; o.rn = 0; o.shift = 0; o.s = 0;
    sess_ops.push_back(o);
    o = mk_op(1); o.cond = 4'hE; o.rd = 4; o.rn = 4; o.rot = 0; o.imm = 1; o.s = 0;
    sess_ops.push_back(o);
    run_session("mov_addi", 8'h30, 8'd2);
    n_cmp++;
    if (obs_data.size() != 2 || obs_data[0] !== 32'hE1A00003 || obs_data[1] !== 32'hE2844001 ||
        obs_addr[1] !== 8'h31) begin
      n_err++;
      $display("FAIL mov_addi_literal: got %0d writes, required e1a00003@30 e2844001@31",
               obs_data.size());
    end

    sess_ops.delete();
    o = mk_op(31); o.cond = 4'hE; o.br = 24'h0; sess_ops.push_back(o);
    o = mk_op(32); o.cond = 4'hE; o.br = 24'h000010; sess_ops.push_back(o);
    o = mk_op(8); o.cond = 4'hE; o.s = 0; sess_ops.push_back(o);
    run_session("branch_cmp", 8'h40, 8'd3);
    n_cmp++;
    if (obs_data.size() != 3 || obs_data[0] !== 32'hEA000000 || obs_data[1] !== 32'hEB000010 ||
        obs_data[2][20] !== 1'b1) begin
      n_err++;
      $display("FAIL branch_cmp_literal: got %0d writes, required ea000000 eb000010 cmp.S=1",
               obs_data.size());
    end
  endtask

  task automatic test_bad_op();
    sess_ops.delete();
    sess_ops.push_back(rand_legal());
    sess_ops.push_back(mk_op(20));
    sess_ops.push_back(rand_legal());
    run_session("bad_op", 8'h50, 8'd2);
    n_cmp++;
    if (obs_addr.size() != 2 || obs_addr[1] !== 8'h51) begin
      n_err++;
      $display("FAIL bad_op_addr: got %0d writes, required second at 51", obs_addr.size());
    end
  endtask

  task automatic test_wrap();
    sess_ops.delete();
    sess_ops.push_back(rand_legal());
    sess_ops.push_back(rand_legal());
    run_session("wrap", 8'hFF, 8'd2);
    n_cmp++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 8'hFF || obs_addr[1] !== 8'h00) begin
      n_err++;
      $display("FAIL wrap_addr: got %0d writes, required ff then 00", obs_addr.size());
    end
  endtask

  task automatic test_count_zero();
    clear_obs();
    do_start(8'h33, 8'd0);
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL count0_done: got %b, required 1", bus.done);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || obs_data.size() != 0) begin
      n_err++;
      $display("FAIL count0_after: got done=%b busy=%b writes=%0d, required 0 0 0",
               bus.done, bus.busy, obs_data.size());
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    bit ok;
    logic [31:0] w;
    op_t o;
    clear_obs();
    d0 = done_cnt;
    do_start(8'h20, 8'd4);
    do_start(8'h80, 8'd0);
    for (int i = 0; i < 4; i++) begin
      o = rand_legal();
      drive_op("b2b", o, ok);
      void'(ref_encode(o, w));
      exp_data.push_back(w);
      exp_xor ^= w;
    end
    wait_done("b2b");
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs_data.size() != 4 || done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL b2b_count: got writes=%0d done=%0d, required 4 1", obs_data.size(),
               done_cnt - d0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs_addr[i] !== 8'(8'h20 + i) || obs_data[i] !== exp_data[i] ||
            (i > 0 && obs_cyc[i] - obs_cyc[i-1] != 2)) begin
          n_err++;
          $display("FAIL b2b_write[%0d]: got %h@%h, required %h@%h every 2 cycles", i,
                   obs_data[i], obs_addr[i], exp_data[i], 8'(8'h20 + i));
        end
      end
    end
  endtask

  task automatic test_random();
    int cnt;
    for (int s = 0; s < 8; s++) begin
      sess_ops.delete();
      cnt = $urandom_range(1, 6);
      for (int i = 0; i < cnt; i++) begin
        if ($urandom_range(0, 4) == 0) sess_ops.push_back(rand_illegal());
        sess_ops.push_back(rand_legal());
      end
      run_session("random", 8'($urandom_range(0, 255)), 8'(cnt));
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit ok;
    clear_obs();
    do_start(8'h60, 8'd3);
    drive_op("rst_mid", rand_legal(), ok);
    n_cmp++;
    if (bus.imem_wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: got wr_en=%b, required 1", bus.imem_wr_en);
    end
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.imem_wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.op_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_now: got wr/busy/rdy=%b%b%b, required 000", bus.imem_wr_en,
               bus.busy, bus.op_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0 || obs_data.size() != 0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_after: got done=%0d writes=%0d busy=%b, required 0 0 0",
               done_cnt - d0, obs_data.size(), bus.busy);
    end
`ifdef INSTR_ENC_CHECKSUM_EN
    n_cmp++;
    if (checksum !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_checksum: got %h, required 0", checksum);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bad_op();
    test_wrap();
    test_count_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
